// File: rtl/dplca_txop_table_ctrl.sv
// DPLCA transmit-opportunity claim table: collects per-TO claims over each PLCA
// cycle, publishes them at every BEACON and ages the table out every aging window.
module dplca_txop_table_ctrl #(
  parameter logic [1:0] BEACON = 2'b00,
  parameter logic [7:0] MAX_ID = 8'd254
) (
  input  logic         clk,
  input  logic         plca_reset,
  input  logic         dplca_en,
  input  logic         plca_en,
  input  logic [15:0]  aging_cycles,
  input  logic [1:0]   rx_cmd,
  input  logic         claim_valid,
  input  logic [7:0]   claim_id,
  input  logic [7:0]   plca_node_count,
  output logic [255:0] txop_claim_table,
  output logic         dplca_txop_table_upd,
  output logic         dplca_new_age,
  output logic [7:0]   dplca_txop_id,
  output logic [7:0]   dplca_txop_node_count,
  output logic [15:0]  age_count
);

  localparam int unsigned NUM_TO = 256;
  localparam int unsigned AGE_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_TO-1:0]   accum;
  logic [7:0]          cyc_max;
  logic                beacon_q;

  logic                beacon_evt_c;
  logic                claim_ok_c;
  logic [NUM_TO-1:0]   claim_vec_c;
  logic [7:0]          max_c;
  logic [AGE_W-1:0]    aging_lim_c;
  logic [AGE_W-1:0]    age_inc_c;
  logic                age_wrap_c;

  // Beacon edge, accepted claim decode and the closing-cycle arithmetic
  always_comb begin
    beacon_evt_c = (rx_cmd == BEACON) && !beacon_q;
    claim_ok_c   = claim_valid && (claim_id <= MAX_ID);
    claim_vec_c  = '0;
    if (claim_ok_c) claim_vec_c[claim_id] = 1'b1;
    max_c        = (claim_ok_c && (claim_id > cyc_max)) ? claim_id : cyc_max;
    aging_lim_c  = (aging_cycles == '0) ? AGE_W'(1) : aging_cycles;
    age_inc_c    = (age_count == '1) ? age_count : age_count + AGE_W'(1);
    age_wrap_c   = age_inc_c >= aging_lim_c;
  end

  always_ff @(posedge clk) begin
    if (plca_reset || !dplca_en || !plca_en) begin
      state                 <= IDLE;
      accum                 <= '0;
      cyc_max               <= '0;
      beacon_q              <= 1'b0;
      txop_claim_table      <= '0;
      dplca_txop_table_upd  <= 1'b0;
      dplca_new_age         <= 1'b0;
      dplca_txop_id         <= '0;
      dplca_txop_node_count <= '0;
      age_count             <= '0;
    end else begin
      beacon_q             <= (rx_cmd == BEACON);
      dplca_txop_table_upd <= 1'b0;
      case (state)
        IDLE: state <= SYNC;
        SYNC: begin
          // First beacon only aligns to the cycle; the partial cycle is dropped
          if (beacon_evt_c) begin
            state     <= RUN;
            accum     <= '0;
            cyc_max   <= '0;
            age_count <= '0;
          end
        end
        RUN: begin
          if (beacon_evt_c) begin
            dplca_txop_table_upd  <= 1'b1;
            dplca_txop_id         <= max_c;
            dplca_txop_node_count <= plca_node_count;
            cyc_max               <= '0;
            if (age_wrap_c) begin
              txop_claim_table <= accum | claim_vec_c;
              accum            <= '0;
              age_count        <= '0;
              dplca_new_age    <= 1'b1;
            end else begin
              // accum keeps the whole window so the next aging close sees it all
              txop_claim_table <= txop_claim_table | accum | claim_vec_c;
              accum            <= accum | claim_vec_c;
              age_count        <= age_inc_c;
              dplca_new_age    <= 1'b0;
            end
          end else begin
            accum   <= accum | claim_vec_c;
            cyc_max <= max_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dplca_txop_table_ctrl.sv
// Randomized scoreboard bench for dplca_txop_table_ctrl against a claim-list
// reference model of the TXOP table rules.
module tb_dplca_txop_table_ctrl;

  logic         clk = 1'b0;
  logic         plca_reset;
  logic         dplca_en;
  logic         plca_en;
  logic [15:0]  aging_cycles;
  logic [1:0]   rx_cmd;
  logic         claim_valid;
  logic [7:0]   claim_id;
  logic [7:0]   plca_node_count;
  logic [255:0] txop_claim_table;
  logic         dplca_txop_table_upd;
  logic         dplca_new_age;
  logic [7:0]   dplca_txop_id;
  logic [7:0]   dplca_txop_node_count;
  logic [15:0]  age_count;

  localparam logic [1:0] CMD_BEACON = 2'b00;
  localparam logic [1:0] CMD_COMMIT = 2'b01;
  localparam logic [1:0] CMD_NONE   = 2'b10;

  dplca_txop_table_ctrl dut (
    .clk                   (clk),
    .plca_reset            (plca_reset),
    .dplca_en              (dplca_en),
    .plca_en               (plca_en),
    .aging_cycles          (aging_cycles),
    .rx_cmd                (rx_cmd),
    .claim_valid           (claim_valid),
    .claim_id              (claim_id),
    .plca_node_count       (plca_node_count),
    .txop_claim_table      (txop_claim_table),
    .dplca_txop_table_upd  (dplca_txop_table_upd),
    .dplca_new_age         (dplca_new_age),
    .dplca_txop_id         (dplca_txop_id),
    .dplca_txop_node_count (dplca_txop_node_count),
    .age_count             (age_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] tbl;
    logic [7:0]   id;
    logic [7:0]   nc;
    logic         na;
    logic [15:0]  age;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  // Reference model: claims kept as ID lists per cycle and per aging window
  int           m_mode;   // 0 idle, 1 waiting for first beacon, 2 running
  bit           m_prev;
  int           m_age;
  logic [255:0] m_table;
  int           cur_ids[$];
  int           win_ids[$];

  function automatic logic [255:0] ids_to_vec(input int ids[$]);
    logic [255:0] v = '0;
    foreach (ids[i]) v[ids[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    bit   evt;
    int   lim;
    int   nxt;
    int   mx;
    exp_t e;
    if (plca_reset || !dplca_en || !plca_en) begin
      m_mode = 0; m_prev = 0; m_age = 0; m_table = '0;
      cur_ids.delete(); win_ids.delete();
      return;
    end
    evt    = (rx_cmd == CMD_BEACON) && !m_prev;
    m_prev = (rx_cmd == CMD_BEACON);
    case (m_mode)
      0: m_mode = 1;
      1: if (evt) begin
        m_mode = 2; m_age = 0;
        cur_ids.delete(); win_ids.delete();
      end
      default: begin
        if (claim_valid && claim_id <= 8'd254) cur_ids.push_back(int'(claim_id));
        if (evt) begin
          mx = 0;
          foreach (cur_ids[i]) begin
            win_ids.push_back(cur_ids[i]);
            if (cur_ids[i] > mx) mx = cur_ids[i];
          end
          lim = (aging_cycles == 0) ? 1 : int'(aging_cycles);
          nxt = (m_age + 1 > 65535) ? 65535 : m_age + 1;
          if (nxt >= lim) begin
            m_table = ids_to_vec(win_ids);
            win_ids.delete();
            m_age = 0;
            e.na  = 1'b1;
          end else begin
            m_table = m_table | ids_to_vec(win_ids);
            m_age   = nxt;
            e.na    = 1'b0;
          end
          e.tbl = m_table;
          e.id  = 8'(mx);
          e.nc  = plca_node_count;
          e.age = 16'(m_age);
          exp_q.push_back(e);
          cur_ids.delete();
        end
      end
    endcase
  endtask

  // Monitor: every publish pulse must match the oldest expected close
  always @(negedge clk) begin
    exp_t e;
    if (dplca_txop_table_upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL upd_unexpected actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk("table", txop_claim_table, e.tbl);
        chk("txop_id", 256'(dplca_txop_id), 256'(e.id));
        chk("node_count", 256'(dplca_txop_node_count), 256'(e.nc));
        chk("new_age", 256'(dplca_new_age), 256'(e.na));
        chk("age_count", 256'(age_count), 256'(e.age));
        chk("bit255", 256'(txop_claim_table[255]), 256'(0));
      end
    end
  end

  task automatic tick(input logic [1:0] rx, input logic cv, input logic [7:0] cid);
    rx_cmd      = rx;
    claim_valid = cv;
    claim_id    = cid;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    tick(CMD_NONE, 1'b0, 8'd0);
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_table"}, txop_claim_table, '0);
    chk({nm, "_upd"}, 256'(dplca_txop_table_upd), 256'(0));
    chk({nm, "_new_age"}, 256'(dplca_new_age), 256'(0));
    chk({nm, "_id"}, 256'(dplca_txop_id), 256'(0));
    chk({nm, "_nc"}, 256'(dplca_txop_node_count), 256'(0));
    chk({nm, "_age"}, 256'(age_count), 256'(0));
  endtask

  task automatic rand_claim(output logic cv, output logic [7:0] cid);
    cv  = ($urandom_range(0, 2) == 0);
    cid = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 60));
  endtask

  initial begin
    logic [255:0] v;
    logic         cv;
    logic [7:0]   cid;
    plca_reset = 1'b1; dplca_en = 1'b1; plca_en = 1'b1;
    aging_cycles = 16'd4; plca_node_count = 8'd6;
    rx_cmd = CMD_NONE; claim_valid = 1'b0; claim_id = 8'd0;
    idle_tick(); idle_tick();
    check_cleared("reset");

    // First beacon aligns only; second closes a cycle with claims 3 and 7
    plca_reset = 1'b0;
    idle_tick(); idle_tick();
    tick(CMD_BEACON, 1'b1, 8'd40);
    idle_tick();
    tick(CMD_COMMIT, 1'b1, 8'd3);
    tick(CMD_NONE, 1'b1, 8'd7);
    idle_tick();
    tick(CMD_BEACON, 1'b0, 8'd0);
    v = '0; v[3] = 1'b1; v[7] = 1'b1;
    chk("t1_upd", 256'(dplca_txop_table_upd), 256'(1));
    chk("t1_table", txop_claim_table, v);
    chk("t1_id", 256'(dplca_txop_id), 256'(7));
    chk("t1_new_age", 256'(dplca_new_age), 256'(0));
    chk("t1_age", 256'(age_count), 256'(1));

    // Claim coinciding with the beacon edge belongs to the closing cycle
    idle_tick(); idle_tick();
    tick(CMD_BEACON, 1'b1, 8'd12);
    chk("t3_id", 256'(dplca_txop_id), 256'(12));
    chk("t3_bit12", 256'(txop_claim_table[12]), 256'(1));

    // Held beacon gives one event; ID 255 is dropped
    idle_tick();
    tick(CMD_COMMIT, 1'b1, 8'd255);
    for (int i = 0; i < 5; i++) tick(CMD_BEACON, 1'b1, (i == 2) ? 8'd255 : 8'd20);
    idle_tick(); idle_tick();

    // Disable mid-cycle clears everything at that edge
    tick(CMD_COMMIT, 1'b1, 8'd33);
    dplca_en = 1'b0;
    idle_tick();
    check_cleared("disable");
    dplca_en = 1'b1;
    idle_tick(); idle_tick();

    // Aging window of two: A{5} B{9} C{2} D{}
    aging_cycles = 16'd2;
    tick(CMD_BEACON, 1'b0, 8'd0);
    tick(CMD_COMMIT, 1'b1, 8'd5); idle_tick();
    tick(CMD_BEACON, 1'b0, 8'd0);
    tick(CMD_COMMIT, 1'b1, 8'd9); idle_tick();
    tick(CMD_BEACON, 1'b0, 8'd0);
    v = '0; v[5] = 1'b1; v[9] = 1'b1;
    chk("t2_b_table", txop_claim_table, v);
    chk("t2_b_new_age", 256'(dplca_new_age), 256'(1));
    tick(CMD_COMMIT, 1'b1, 8'd2); idle_tick();
    tick(CMD_BEACON, 1'b0, 8'd0);
    idle_tick(); idle_tick();
    tick(CMD_BEACON, 1'b0, 8'd0);
    v = '0; v[2] = 1'b1;
    chk("t2_d_table", txop_claim_table, v);
    chk("t2_d_new_age", 256'(dplca_new_age), 256'(1));

    // Zero aging window behaves as one
    aging_cycles = 16'd0;
    for (int c = 0; c < 4; c++) begin
      plca_node_count = 8'(c + 10);
      tick(CMD_COMMIT, 1'b1, 8'(c * 7 + 1));
      idle_tick();
      tick(CMD_BEACON, 1'b0, 8'd0);
      chk("t6_new_age", 256'(dplca_new_age), 256'(1));
    end

    // Randomized cycles, windows, node counts, disables and resets
    for (int c = 0; c < 160; c++) begin
      int hold;
      int len;
      if ($urandom_range(0, 7) == 0) aging_cycles = 16'($urandom_range(0, 4));
      plca_node_count = 8'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) == 0) plca_en = 1'b0; else plca_reset = 1'b1;
        idle_tick();
        plca_en = 1'b1; plca_reset = 1'b0;
      end
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        rand_claim(cv, cid);
        tick(CMD_BEACON, cv, cid);
      end
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        rand_claim(cv, cid);
        tick(($urandom_range(0, 1) == 0) ? CMD_COMMIT : CMD_NONE, cv, cid);
      end
    end

    idle_tick(); idle_tick(); idle_tick();
    chk("pending_expect", 256'(exp_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
